// File: rtl/ingress_queue_pkg.sv
// Shared widths, defaults and the round-robin pick helper for the ingress queue array.
package ingress_queue_pkg;

  localparam int DEFAULT_NUMBER_OF_INPUTS = 2;
  localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
  localparam int DEFAULT_QUEUE_LENGTH     = 16;

  // Upper bound on ingress ports the arbiter helper can scan, and its index width.
  localparam int MAX_INPUTS = 64;
  localparam int RR_IDX_W   = 6;

  function automatic int count_width(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic int ptr_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  function automatic int qid_width(input int nq);
    return (nq > 1) ? $clog2(nq) : 1;
  endfunction

  function automatic int rr_width(input int ni);
    return (ni > 1) ? $clog2(ni) : 1;
  endfunction

  localparam int COUNT_W = count_width(DEFAULT_QUEUE_LENGTH);
  localparam int PTR_W   = ptr_width(DEFAULT_QUEUE_LENGTH);
  localparam int QID_W   = qid_width(DEFAULT_NUMBER_OF_QUEUES);
  localparam int RR_W    = rr_width(DEFAULT_NUMBER_OF_INPUTS);

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan the n request bits cyclically starting at ptr and return the first one set.
  function automatic rr_pick_t rr_pick(input logic [MAX_INPUTS-1:0] req,
                                       input int ptr,
                                       input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_INPUTS; k++) begin
      if (k < n && !r.found) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j]) begin
          r.found = 1'b1;
          r.idx   = RR_IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ingress_queue_array_reg_fifo.sv
// One register FIFO queue: storage, pointers, occupancy flags and kill_the_core hysteresis.
module reg_fifo
  import ingress_queue_pkg::*;
#(
  parameter int DATA_SIZE     = 678,
  parameter int QUEUE_LENGTH  = 16,
  parameter int REGISTER_SIZE = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push,
  input  logic [DATA_SIZE-1:0]               push_data,
  input  logic                               pop,
  input  logic [REGISTER_SIZE-1:0]           high_threshold,
  input  logic [REGISTER_SIZE-1:0]           low_threshold,
  output logic [DATA_SIZE-1:0]               head_packet,
  output logic                               empty,
  output logic                               full,
  output logic                               last_elem,
  output logic [$clog2(QUEUE_LENGTH+1)-1:0]  count,
  output logic                               kill_the_core
);

  localparam int CNT_W = count_width(QUEUE_LENGTH);
  localparam int PW    = ptr_width(QUEUE_LENGTH);

  logic [DATA_SIZE-1:0]     storage [QUEUE_LENGTH];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic                     do_push;
  logic                     do_pop;
  logic [CNT_W-1:0]         next_count;
  logic [REGISTER_SIZE-1:0] next_count_ext;
  logic                     next_kill;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(QUEUE_LENGTH));
  assign last_elem   = (count == CNT_W'(1));
  assign head_packet = storage[rd_ptr];

  // Effective push/pop and the occupancy that will be visible after this edge.
  always_comb begin
    do_push    = push && !full;
    do_pop     = pop && !empty;
    next_count = count;
    if (do_push && !do_pop) begin
      next_count = count + 1'b1;
    end else if (!do_push && do_pop) begin
      next_count = count - 1'b1;
    end
    next_count_ext = REGISTER_SIZE'(next_count);
  end

  // Kill hysteresis on the post-update count; a zero high level disables it, set wins over clear.
  always_comb begin
    next_kill = kill_the_core;
    if (high_threshold == '0) begin
      next_kill = 1'b0;
    end else if (next_count_ext >= high_threshold) begin
      next_kill = 1'b1;
    end else if (next_count_ext <= low_threshold) begin
      next_kill = 1'b0;
    end
  end

  // Packet storage is data only and deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointer, occupancy and throttle state; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      kill_the_core <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count         <= next_count;
      kill_the_core <= next_kill;
    end
  end

endmodule

// File: rtl/ingress_queue_array.sv
// Ingress crossbar: per-queue round-robin arbiters, backpressure, stall counters and queue bank.
module ingress_queue_array
  import ingress_queue_pkg::*;
#(
  parameter int NUMBER_OF_INPUTS = 2,
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int QUEUE_LENGTH     = 16,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                                    clock,
  input  logic                                                    reset,
  input  logic [NUMBER_OF_INPUTS-1:0][DATA_SIZE-1:0]              in_packet,
  input  logic [NUMBER_OF_INPUTS-1:0]                             in_valid,
  input  logic [NUMBER_OF_INPUTS-1:0][$clog2(NUMBER_OF_QUEUES)-1:0] in_id,
  output logic [NUMBER_OF_INPUTS-1:0]                             in_ready,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]          high_threshold,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]          low_threshold,
  input  logic [NUMBER_OF_QUEUES-1:0]                             consumed,
  output logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0]              head_packet,
  output logic [NUMBER_OF_QUEUES-1:0]                             empty,
  output logic [NUMBER_OF_QUEUES-1:0]                             full,
  output logic [NUMBER_OF_QUEUES-1:0]                             lastElem,
  output logic [NUMBER_OF_QUEUES-1:0][$clog2(QUEUE_LENGTH+1)-1:0] count,
  output logic [NUMBER_OF_QUEUES-1:0]                             kill_the_core,
  output logic [NUMBER_OF_INPUTS-1:0][REGISTER_SIZE-1:0]          stall_cycles
);

  localparam int ARB_W = rr_width(NUMBER_OF_INPUTS);

  logic [ARB_W-1:0]                          rr_ptr    [NUMBER_OF_QUEUES];
  logic [ARB_W-1:0]                          grant_idx [NUMBER_OF_QUEUES];
  logic [NUMBER_OF_QUEUES-1:0]               grant_valid;
  logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0] push_data;

  // Per-queue arbitration: collect requesters, pick round-robin, block when the queue is full.
  always_comb begin
    logic [MAX_INPUTS-1:0] req;
    rr_pick_t              pick;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      req = '0;
      for (int i = 0; i < NUMBER_OF_INPUTS; i++) begin
        req[i] = in_valid[i] && (int'(in_id[i]) == q);
      end
      pick           = rr_pick(req, int'(rr_ptr[q]), NUMBER_OF_INPUTS);
      grant_valid[q] = pick.found && !full[q];
      grant_idx[q]   = ARB_W'(pick.idx);
      push_data[q]   = in_packet[grant_idx[q]];
    end
  end

  // An input is ready when some queue granted it, or when its id names no queue (dropped).
  always_comb begin
    for (int i = 0; i < NUMBER_OF_INPUTS; i++) begin
      in_ready[i] = (int'(in_id[i]) >= NUMBER_OF_QUEUES);
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if (grant_valid[q] && (int'(grant_idx[q]) == i)) begin
          in_ready[i] = 1'b1;
        end
      end
    end
  end

  // Round-robin pointers move just past the last winner of each queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        rr_ptr[q] <= '0;
      end
    end else begin
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
        if (grant_valid[q]) begin
          if (int'(grant_idx[q]) == NUMBER_OF_INPUTS - 1) begin
            rr_ptr[q] <= '0;
          end else begin
            rr_ptr[q] <= grant_idx[q] + 1'b1;
          end
        end
      end
    end
  end

  // Saturating count of cycles each input offered a packet that was not taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_INPUTS; i++) begin
        if (in_valid[i] && !in_ready[i] && (stall_cycles[i] != '1)) begin
          stall_cycles[i] <= stall_cycles[i] + 1'b1;
        end
      end
    end
  end

  for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_queue
    reg_fifo #(
      .DATA_SIZE     (DATA_SIZE),
      .QUEUE_LENGTH  (QUEUE_LENGTH),
      .REGISTER_SIZE (REGISTER_SIZE)
    ) u_fifo (
      .clock          (clock),
      .reset          (reset),
      .push           (grant_valid[q]),
      .push_data      (push_data[q]),
      .pop            (consumed[q]),
      .high_threshold (high_threshold[q]),
      .low_threshold  (low_threshold[q]),
      .head_packet    (head_packet[q]),
      .empty          (empty[q]),
      .full           (full[q]),
      .last_elem      (lastElem[q]),
      .count          (count[q]),
      .kill_the_core  (kill_the_core[q])
    );
  end

endmodule

// File: doc/ingress_queue_array.md
Name: ingress_queue_array

Overview:
Parametrised successor to the two-dispatcher, fixed-four-queue ingress stage. It accepts packets from NUMBER_OF_INPUTS packetizer ports, each tagged with a full queue id. A per-queue round-robin crossbar routes every packet into one of NUMBER_OF_QUEUES register FIFOs. It adds backpressure, collision arbitration, kill_the_core hysteresis and per-input stall counters, and feeds the existing selector/scheduler through the empty/full/lastElem/head interface.

Parameters:
NUMBER_OF_INPUTS, 2, number of packetizer ingress ports (>=1)
NUMBER_OF_QUEUES, 4, number of queues (>=2, need not be a power of 2)
DATA_SIZE, 678, packet width in bits
QUEUE_LENGTH, 16, FIFO depth per queue (power of 2, >=2)
REGISTER_SIZE, 32, width of thresholds and stall counters

Ports:
clock  in  1  single clock for the block
reset  in  1  asynchronous, active-low reset
in_packet  in  [NUMBER_OF_INPUTS][DATA_SIZE]  packet per input
in_valid  in  [NUMBER_OF_INPUTS]  packet present
in_id  in  [NUMBER_OF_INPUTS][$clog2(NUMBER_OF_QUEUES)]  target queue
in_ready  out  [NUMBER_OF_INPUTS]  transfer occurs when in_valid & in_ready
high_threshold  in  [NUMBER_OF_QUEUES][REGISTER_SIZE]  kill set level; 0 disables
low_threshold  in  [NUMBER_OF_QUEUES][REGISTER_SIZE]  kill clear level
consumed  in  [NUMBER_OF_QUEUES]  pop strobe from scheduler
head_packet  out  [NUMBER_OF_QUEUES][DATA_SIZE]  oldest entry per queue
empty  out  [NUMBER_OF_QUEUES]  count==0
full  out  [NUMBER_OF_QUEUES]  count==QUEUE_LENGTH
lastElem  out  [NUMBER_OF_QUEUES]  count==1
count  out  [NUMBER_OF_QUEUES][$clog2(QUEUE_LENGTH+1)]  occupancy
kill_the_core  out  [NUMBER_OF_QUEUES]  throttle request, registered
stall_cycles  out  [NUMBER_OF_INPUTS][REGISTER_SIZE]  saturating count of in_valid & !in_ready cycles

Behaviour:
- Reset (reset==0, async): counts 0, read/write pointers 0, rr pointers 0, kill_the_core 0, stall_cycles 0. Storage is not reset. head_packet is unspecified while empty.
- Request: input i requests queue q when in_valid[i] && in_id[i]==q.
- Grant: when queue q is not full, grant the first requester in cyclic order starting at rr[q]. When full, no grant is given.
- in_ready[i] is combinational: it is 1 iff input i is granted, or iff in_id[i] >= NUMBER_OF_QUEUES. Invalid-id packets are accepted and discarded, with no queue effect.
- in_ready does not depend on consumed in the same cycle; a full queue never accepts, even if it is popped that cycle.
- A losing input must hold packet and id stable until accepted.
- After an accepted push to q by input w: rr[q] <= (w+1) mod NUMBER_OF_INPUTS. Otherwise rr[q] is unchanged.
- Push at edge T: empty, count and head_packet update at T+1. Pop: consumed[q] && !empty[q] advances the read pointer at the edge. consumed on an empty queue is ignored.
- Push and pop in the same cycle: count is unchanged, and both pointers advance. Pointers wrap modulo QUEUE_LENGTH.
- At most one push per queue per cycle. Different queues accept in parallel.
- kill_the_core[q], evaluated each edge on the post-update count c:
  - set when high_threshold[q]!=0 && c>=high_threshold[q]
  - clear when c<=low_threshold[q]
  - otherwise hold
  - if high_threshold[q]==0, forced to 0
  - if low>=high, set takes priority
- stall_cycles[i] increments by 1 per cycle with in_valid[i] && !in_ready[i], and saturates at all-ones.
- Threshold compare is zero-extended: count widened to REGISTER_SIZE.

Decomposition:
- Package ingress_queue_pkg holds: COUNT_W=$clog2(QUEUE_LENGTH+1), PTR_W=$clog2(QUEUE_LENGTH), QID_W, the RR-pointer width, and a function rr_pick(req, ptr) returning the winner index and a found flag.
- Sub-module reg_fifo holds one queue: storage, pointers, count, flags and kill hysteresis.
- The top holds the crossbar/arbiters, in_ready and the stall counters, and generates NUMBER_OF_QUEUES reg_fifo instances.

Test Plan:
- Single input, id=2, push 3 packets A,B,C then 3 pops -> count[2]=1,2,3 at T+1, T+2, T+3; head A,B,C in order; empty[2]=1 after the last pop; lastElem[2]=1 exactly when count==1.
- Inputs 0 and 1 both hold valid with id=1 for 4 cycles -> grants alternate 0,1,0,1 (rr starts 0); in_ready never 1 for both; stall_cycles = 2 and 2.
- Fill queue 0 to 16 -> full=1, in_ready=0; stall_cycles increments each held cycle. Apply consumed with valid held -> the push occurs one cycle later, never the same cycle. count stays <=16.
- Set high=4, low=1, push 5, pop 4 -> kill rises the edge count reaches 4, stays 1 at count 3 and 2, falls when count reaches 1. Repeat with high=0 -> kill stays 0.
- Push and pop in the same cycle on count=5 -> count stays 5 and head advances. Pop on an empty queue -> no change.
- Assert reset mid-traffic with count=7 -> all counts 0, kill 0 and stall 0 immediately, without a clock edge. Traffic after release starts from rr=0.
